// File: rtl/integration_scheduler.sv
// integration_scheduler: sample-period sequencer for an integrate-and-dump datapath.
// Optional feature: define INTEG_SCHED_OVERRUN_CNT_EN to build the saturating overrun counter.
module integration_scheduler #(
  parameter int unsigned CNT_W      = 14,
  parameter int unsigned EPOCH_W    = 8,
  parameter int unsigned PERIOD_DEF = 1000
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               sample_en,
  input  logic [CNT_W-1:0]   period_in,
  input  logic               period_wr,
  output logic               clear_acc,
  output logic               dump,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [EPOCH_W-1:0] epoch,
  output logic               busy,
  output logic [7:0]         overrun_cnt
);

  localparam logic [CNT_W-1:0] PeriodDef = CNT_W'(PERIOD_DEF);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, r_shadow, r_active;
  logic [CNT_W-1:0]   w_period_fix, w_shadow_next;
  logic [EPOCH_W-1:0] r_epoch;
  logic               r_dump_valid;
  logic               w_first, w_last;

  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == r_active - CNT_W'(1));

  // A zero period would never dump; treat it as one sample per period.
  assign w_period_fix  = (period_in == '0) ? CNT_W'(1) : period_in;
  assign w_shadow_next = period_wr ? w_period_fix : r_shadow;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (start && !stop) w_state_next = StRun;
      StRun:   if (stop) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Stop on the last sample abandons the period, so it also masks dump.
  always_comb begin
    busy      = (r_state == StRun);
    clear_acc = busy && sample_en && w_first;
    dump      = busy && sample_en && !stop && w_last;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state != w_state_next) begin
      r_cnt <= '0;
    end else if ((r_state == StRun) && sample_en) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)       r_epoch <= '0;
    else if (dump) r_epoch <= r_epoch + EPOCH_W'(1);
  end

  // New periods apply at once when idle, otherwise only at a period boundary.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_shadow <= PeriodDef;
      r_active <= PeriodDef;
    end else begin
      r_shadow <= w_shadow_next;
      if ((r_state == StIdle) || dump) r_active <= w_shadow_next;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)             r_dump_valid <= 1'b0;
    else if (dump)       r_dump_valid <= 1'b1;
    else if (dump_ready) r_dump_valid <= 1'b0;
  end

  assign dump_valid = r_dump_valid;
  assign epoch      = r_epoch;

`ifdef INTEG_SCHED_OVERRUN_CNT_EN
  logic [7:0] r_overrun;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_overrun <= 8'd0;
    end else if (dump && r_dump_valid && !dump_ready && (r_overrun != 8'hFF)) begin
      r_overrun <= r_overrun + 8'd1;
    end
  end

  assign overrun_cnt = r_overrun;
`else
  assign overrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_integration_scheduler.sv
// Bench for integration_scheduler: directed scenarios plus randomized traffic against
// a sample-counting reference model.
`timescale 1ns/1ps
module tb_integration_scheduler;

  localparam int CNT_W      = 14;
  localparam int EPOCH_W    = 8;
  localparam int PERIOD_DEF = 1000;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0, stop = 1'b0, sample_en = 1'b0;
  logic               period_wr = 1'b0, dump_ready = 1'b0;
  logic [CNT_W-1:0]   period_in = '0;
  logic               clear_acc, dump, dump_valid, busy;
  logic [EPOCH_W-1:0] epoch;
  logic [7:0]         overrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  integration_scheduler #(
    .CNT_W     (CNT_W),
    .EPOCH_W   (EPOCH_W),
    .PERIOD_DEF(PERIOD_DEF)
  ) dut (
    .clk_in     (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .sample_en  (sample_en),
    .period_in  (period_in),
    .period_wr  (period_wr),
    .clear_acc  (clear_acc),
    .dump       (dump),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .epoch      (epoch),
    .busy       (busy),
    .overrun_cnt(overrun_cnt)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: m_taken = samples already taken in the current period.
  bit m_run;
  int m_taken, m_epoch, m_shadow, m_active, m_valid, m_ovr;

  function automatic int fix_period(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  function automatic bit exp_dump();
    return m_run && sample_en && !stop && (m_taken + 1 == m_active);
  endfunction

  function automatic bit exp_clear();
    return m_run && sample_en && (m_taken == 0);
  endfunction

  function automatic int exp_ovr();
`ifdef INTEG_SCHED_OVERRUN_CNT_EN
    return m_ovr;
`else
    return 0;
`endif
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_run = 1'b0; m_taken = 0; m_epoch = 0; m_valid = 0; m_ovr = 0;
      m_shadow = PERIOD_DEF; m_active = PERIOD_DEF;
    end else begin : model_step
      bit d;
      bit was_run;
      int nsh;
      d       = exp_dump();
      was_run = m_run;
      nsh     = period_wr ? fix_period(int'(period_in)) : m_shadow;
      if (!was_run || d) m_active = nsh;
      m_shadow = nsh;
      if (d) begin
        if (m_valid != 0 && !dump_ready && m_ovr < 255) m_ovr++;
        m_valid = 1;
      end else if (m_valid != 0 && dump_ready) begin
        m_valid = 0;
      end
      if (was_run) begin
        if (stop) begin
          m_run = 1'b0; m_taken = 0;
        end else if (sample_en) begin
          if (d) begin
            m_taken = 0;
            m_epoch = (m_epoch + 1) % (1 << EPOCH_W);
          end else begin
            m_taken++;
          end
        end
      end else if (start && !stop) begin
        m_run = 1'b1; m_taken = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("busy",        int'(busy),        int'(m_run));
      chk("clear_acc",   int'(clear_acc),   int'(exp_clear()));
      chk("dump",        int'(dump),        int'(exp_dump()));
      chk("dump_valid",  int'(dump_valid),  m_valid);
      chk("epoch",       int'(epoch),       m_epoch);
      chk("overrun_cnt", int'(overrun_cnt), exp_ovr());
    end
  end

  // Called just after a rising edge; samples combinational outputs mid-cycle.
  task automatic cyc(input bit st, input bit sp, input bit se, input bit pw, input int pin,
                     input bit rdy, output bit d, output bit c, output bit b);
    start = st; stop = sp; sample_en = se; period_wr = pw;
    period_in = CNT_W'(pin); dump_ready = rdy;
    #3;
    d = dump; c = clear_acc; b = busy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0; stop = 1'b0; sample_en = 1'b0; period_wr = 1'b0;
    period_in = '0; dump_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic samples_to_dump(input int bound, output int k);
    bit d, c, b;
    k = -1;
    for (int i = 1; i <= bound; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, d, c, b);
      if (d) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit d, c, b;
    int k, n_clear, first_dump, n_dump;
    do_reset();
    chk("reset_busy",   int'(busy),       0);
    chk("reset_epoch",  int'(epoch),      0);
    chk("reset_valid",  int'(dump_valid), 0);

    // Default period: dump on sample 1000, clear on samples 1 and 1001.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, d, c, b);
    n_clear = 0; first_dump = 0;
    for (int i = 1; i <= 1001; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, d, c, b);
      if (c) n_clear++;
      if (d && first_dump == 0) first_dump = i;
      if (i == 1) chk("clear_at_1", int'(c), 1);
      if (i == 1001) chk("clear_at_1001", int'(c), 1);
    end
    chk("first_dump_sample", first_dump, 1000);
    chk("clear_count",       n_clear,    2);
    chk("epoch_after_one",   int'(epoch), 1);

    // Mid-period write of 4: current period still runs to 1000.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b1, d, c, b);
    samples_to_dump(2000, k);
    chk("dump_after_write", k, 999);
    samples_to_dump(50, k);
    chk("dump_short_period", k, 4);

    // Period 0 written while idle behaves as 1.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, d, c, b);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, d, c, b);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, d, c, b);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, (i != 2), 1'b0, 0, 1'b1, d, c, b);
      chk("p1_dump",  int'(d), (i != 2) ? 1 : 0);
      chk("p1_clear", int'(c), (i != 2) ? 1 : 0);
    end

    // Consumer stalled: three dumps in six samples.
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0, d, c, b);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, d, c, b);
    n_dump = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, d, c, b);
      if (d) n_dump++;
    end
    chk("stall_dumps",   n_dump,           3);
    chk("valid_held",    int'(dump_valid), 1);
`ifdef INTEG_SCHED_OVERRUN_CNT_EN
    chk("overrun_value", int'(overrun_cnt), 2);
`else
    chk("overrun_value", int'(overrun_cnt), 0);
`endif

    // Stop mid-period and restart from scratch.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, d, c, b);
    n_dump = 0;
    for (int i = 0; i < 500; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, d, c, b);
      if (d) n_dump++;
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, d, c, b);
    if (d) n_dump++;
    chk("no_dump_before_stop", n_dump, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, d, c, b);
    chk("busy_after_stop", int'(b), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, d, c, b);
    samples_to_dump(2000, k);
    chk("dump_after_restart", k, 1000);

    // Randomized traffic, short periods, occasional resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 14) == 0),
            int'($urandom_range(0, 6)), ($urandom_range(0, 1) == 1), d, c, b);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/integration_scheduler.md
INTEGRATION_SCHEDULER -- requirements
Module: integration_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 14, sample-counter and period width.
REQ-002 SHALL have parameter EPOCH_W, default 8, epoch counter width.
REQ-003 SHALL have parameter PERIOD_DEF, default 1000, active period after reset.
REQ-004 SHALL have port clk_in  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  single-cycle request to begin integrating.
REQ-007 SHALL have port stop  input  1  single-cycle request to abort integrating.
REQ-008 SHALL have port sample_en  input  1  sample qualifier; counting advances only when high.
REQ-009 SHALL have port period_in  input  CNT_W  requested samples per integration period.
REQ-010 SHALL have port period_wr  input  1  write strobe for period_in.
REQ-011 SHALL have port clear_acc  output  1  first sample of a period (accumulator loads, not adds).
REQ-012 SHALL have port dump  output  1  last sample of a period.
REQ-013 SHALL have port dump_valid  output  1  completed period awaiting consumer.
REQ-014 SHALL have port dump_ready  input  1  consumer accepts completed period.
REQ-015 SHALL have port epoch  output  EPOCH_W  count of completed periods, wraps.
REQ-016 SHALL have port busy  output  1  high in RUN state.
REQ-017 SHALL have port overrun_cnt  output  8  dumps lost to unaccepted dump_valid.

Function
REQ-018 SHALL implement two states, IDLE and RUN; busy = (state == RUN).
REQ-019 IDLE -> RUN on start with stop low; RUN -> IDLE on stop; stop has priority over start in the same cycle.
REQ-020 Entering RUN and leaving RUN SHALL clear sample counter cnt to 0; epoch SHALL be retained.
REQ-021 In RUN with sample_en: if cnt == active_period-1 then cnt <= 0 and epoch <= epoch+1 (wraps), else cnt <= cnt+1; without sample_en cnt holds.
REQ-022 clear_acc SHALL be combinational: RUN & sample_en & cnt == 0.
REQ-023 dump SHALL be combinational: RUN & sample_en & cnt == active_period-1; zero latency.
REQ-024 Stop in the same cycle as a qualifying last sample SHALL suppress dump and epoch increment.
REQ-025 period_wr SHALL load a shadow register; period_in of 0 SHALL be stored as 1.
REQ-026 Shadow SHALL copy to active_period immediately in IDLE, and in RUN only in a dump cycle (takes effect from next period).
REQ-027 period_wr in the dump cycle SHALL take effect at that same boundary (write-through to active).
REQ-028 With active_period 1, clear_acc and dump SHALL both assert on every qualifying sample.
REQ-029 dump_valid SHALL set the cycle after dump and clear the cycle after dump_valid & dump_ready.
REQ-030 dump while dump_valid & dump_ready SHALL keep dump_valid high with no overrun.
REQ-031 dump while dump_valid & !dump_ready SHALL keep dump_valid high and count one overrun.

Reset
REQ-032 rst SHALL asynchronously force IDLE, cnt 0, epoch 0, dump_valid 0, overrun_cnt 0, shadow and active_period PERIOD_DEF.
REQ-033 rst mid-period SHALL discard the partial period with no dump issued.

Configuration
REQ-034 Macro INTEG_SCHED_OVERRUN_CNT_EN defined: overrun_cnt increments per REQ-031, saturates at 255, clears only on rst.
REQ-035 Macro undefined: overrun_cnt SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-036 Reset, start, period 1000, sample_en constant -> dump on 1000th sample, clear_acc on 1st and 1001st, epoch 1.
REQ-037 period_wr 4 mid-period of 1000 -> current period completes at 1000, next dump after 4 samples.
REQ-038 period_wr 0 in IDLE, start -> dump and clear_acc every sample_en cycle.
REQ-039 dump_ready low, period 2, six samples -> dump_valid stays high, overrun_cnt 2 (0 without macro).
REQ-040 stop at cnt 500, restart -> busy drops next cycle, no dump, next dump 1000 samples after restart.
